ram_access_controller: RTL and testbench

//  Initiator for the 256x32 word RAM (8-bit Address, 32-bit Din/Dout, RW strobe).

---
 rtl/ram_ctrl_pkg.sv | 22 ++
 rtl/ram_rsp_fifo.sv | 69 ++++++
 rtl/ram_access_controller.sv | 196 +++++++++++++++++++
 tb/tb_ram_access_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_ctrl_pkg
//  Description : Shared types and widths for the RAM access controller:
//                controller state encoding and address/data/length widths.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rsp_fifo
//  Description : Synchronous response FIFO holding {last, data} read beats.
//                Push and pop in the same cycle are allowed. The head word
//                reads as zero while empty so the response port is clean
//                straight out of reset.
//  Ports       : clk, rst (async, active-high)
//                push / push_data  - write a word at the tail
//                pop               - remove the head word (only when !empty)
//                head / empty      - head word, empty flag
//                count             - current occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module ram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ram_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : ram_access_controller
//  Description : Burst initiator for a 256x32 RAM. Accepts one read or write
//                burst command (1..4 words) at a time, drives Address/Din/RW
//                and returns read data through a response FIFO.
//  Ports       : clk, rst (async, active-high)
//                cmd_valid/ready/write/addr/len - burst command
//                wd_valid/ready/data             - write-data beats
//                rsp_valid/ready/data/last       - read-data beats
//                mem_addr/din/rw, mem_dout       - RAM interface (rw 1=read)
//                stat_rd/stat_wr                 - beat counters (optional)
//  Options     : RAM_CTRL_STATS_EN adds saturating stat_rd/stat_wr outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_access_controller
    import ram_ctrl_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_dout
`ifdef RAM_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_rd,
    output logic [15:0]       stat_wr
`endif
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_init;      // holds cmd_ready low for the first cycle after reset
    logic [ADDR_W-1:0] r_cur;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;       // beats issued so far in the current burst
    logic [RD_LAT-1:0] r_pipe_v;    // read issued N+1 cycles ago
    logic [RD_LAT-1:0] r_pipe_l;    // ... and it was the final beat

    logic              w_issue;
    logic              w_wd_hs;
    logic              w_last_beat;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [CW-1:0]     w_fifo_count;
    logic [CW:0]       w_inflight;
    logic [CW:0]       w_used;
    logic [DATA_W:0]   w_head;

    assign w_last_beat = (r_cnt == r_len);
    assign w_wd_hs     = wd_valid & wd_ready;
    assign w_push      = r_pipe_v[RD_LAT-1];
    assign w_pop       = rsp_valid & rsp_ready;

    // Credit: words already buffered plus reads still in the RAM pipe must
    // leave room for one more, so the FIFO can never overflow.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + (CW + 1)'(r_pipe_v[i]);
        end
    end
    assign w_used = {1'b0, w_fifo_count} + w_inflight;

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        wd_ready    = 1'b0;
        w_issue     = 1'b0;
        mem_addr    = r_cur;
        mem_din     = '0;
        mem_rw      = 1'b1;
        case (r_state)
            IDLE: begin
                cmd_ready = r_init;
                if (cmd_valid && r_init) begin
                    w_state_nxt = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wd_ready = 1'b1;
                if (wd_valid) begin
                    mem_din = wd_data;
                    mem_rw  = 1'b0;
                    if (w_last_beat) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            READ: begin
                if (w_used < (CW + 1)'(RSP_DEPTH)) begin
                    w_issue = 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_pop && rsp_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_init   <= 1'b0;
            r_cur    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_pipe_v <= '0;
            r_pipe_l <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_init  <= 1'b1;
            if (cmd_valid && cmd_ready) begin
                r_cur <= cmd_addr;
                r_len <= cmd_len;
                r_cnt <= '0;
            end else if (w_wd_hs || w_issue) begin
                r_cur <= r_cur + 1'b1;   // wraps FF -> 00 naturally
                r_cnt <= r_cnt + 1'b1;
            end
            r_pipe_v[0] <= w_issue;
            r_pipe_l[0] <= w_issue & w_last_beat;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_l[i] <= r_pipe_l[i-1];
            end
        end
    end

    ram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({r_pipe_l[RD_LAT-1], mem_dout}),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .count     (w_fifo_count)
    );

    assign rsp_valid = ~w_empty;
    assign rsp_last  = w_head[DATA_W];
    assign rsp_data  = w_head[DATA_W-1:0];

`ifdef RAM_CTRL_STATS_EN
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else begin
            if (w_push && (r_stat_rd != 16'hFFFF)) begin
                r_stat_rd <= r_stat_rd + 1'b1;
            end
            if (w_wd_hs && (r_stat_wr != 16'hFFFF)) begin
                r_stat_wr <= r_stat_wr + 1'b1;
            end
        end
    end

    assign stat_rd = r_stat_rd;
    assign stat_wr = r_stat_wr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_access_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_access_controller
//  Description : Scoreboard bench for ram_access_controller with a behavioural
//                RAM, a shadow memory reference and randomised bursts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_access_controller;

    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [1:0]  cmd_len = '0;
    logic        wd_valid = 1'b0;
    logic        wd_ready;
    logic [31:0] wd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_rw;
    logic [31:0] mem_dout;
`ifdef RAM_CTRL_STATS_EN
    logic [15:0] stat_rd;
    logic [15:0] stat_wr;
`endif

    always #5 clk = ~clk;

    ram_access_controller #(
        .RD_LAT    (RD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_rw    (mem_rw),
        .mem_dout  (mem_dout)
`ifdef RAM_CTRL_STATS_EN
        ,
        .stat_rd   (stat_rd),
        .stat_wr   (stat_wr)
`endif
    );

    // ---------------- behavioural RAM: Dout valid RD_LAT cycles after address
    function automatic logic [31:0] init_val(input int i);
        return 32'h5A000000 ^ (i * 32'h00010203);
    endfunction

    logic [31:0] ram [256];
    logic [31:0] rd_q [RD_LAT];
    bit          ram_inited = 1'b0;

    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_inited <= 1'b1;
        end else if (!mem_rw) begin
            ram[mem_addr] <= mem_din;
        end
        rd_q[0] <= ram[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_q[i] <= rd_q[i-1];
    end
    assign mem_dout = rd_q[RD_LAT-1];

    // ---------------- reference model and scoreboard
    typedef struct packed { logic last; logic [31:0] data; } rsp_t;
    typedef struct packed { logic [7:0] addr; logic [31:0] data; } wr_t;

    logic [31:0] exp_mem [256];
    rsp_t        rq[$];
    wr_t         wq[$];
    int          checks = 0;
    int          errors = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    int          rdy_mode = 2;   // 0 random, 1 hold low, 2 always high

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    // Response / RAM-bus monitor
    always @(negedge clk) begin
        rsp_t e;
        wr_t  w;
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got=%h/%b required=none", rsp_data, rsp_last);
                end else begin
                    e = rq.pop_front();
                    if (rsp_data !== e.data || rsp_last !== e.last) begin
                        errors++;
                        $display("FAIL rsp_beat got=%h/%b required=%h/%b",
                                 rsp_data, rsp_last, e.data, e.last);
                    end
                end
            end
            if (mem_rw === 1'b0) begin
                checks++;
                if (wq.size() == 0 || !(wd_valid && wd_ready)) begin
                    errors++;
                    $display("FAIL mem_write_unexpected got=%h@%h required=none", mem_din, mem_addr);
                end else begin
                    w = wq.pop_front();
                    if (mem_addr !== w.addr || mem_din !== w.data) begin
                        errors++;
                        $display("FAIL mem_write got=%h@%h required=%h@%h",
                                 mem_din, mem_addr, w.data, w.addr);
                    end
                end
            end else if (wd_valid && wd_ready) begin
                checks++;
                errors++;
                $display("FAIL wd_handshake_without_write got=rw%b required=rw0", mem_rw);
            end
        end
    end

    // Consumer-side ready driver
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       rsp_ready = 1'($urandom_range(0, 1));
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus tasks (entered at posedge+1)
    task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [1:0] l);
        int n = 0;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout got=ready0 required=ready1");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [1:0] l, input bit rnd,
                            input logic [31:0] base, input bit gaps);
        logic [7:0]  idx;
        logic [31:0] d;
        int          n;
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    chk("cmd_ready_in_write_gap", {31'd0, cmd_ready}, 32'd0);
                    @(posedge clk);
                    #1;
                end
            end
            d        = rnd ? $urandom : base + 32'(i);
            idx      = a + 8'(i);
            wd_data  = d;
            wd_valid = 1'b1;
            wq.push_back('{addr: idx, data: d});
            exp_mem[idx] = d;
            n_wr++;
            n = 0;
            @(negedge clk);
            while (!wd_ready && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (!wd_ready) begin
                checks++;
                errors++;
                $display("FAIL wd_timeout got=ready0 required=ready1");
            end
            chk("cmd_ready_in_write", {31'd0, cmd_ready}, 32'd0);
            @(posedge clk);
            #1;
            wd_valid = 1'b0;
        end
    endtask

    task automatic do_read(input logic [7:0] a, input logic [1:0] l);
        logic [7:0] idx;
        send_cmd(1'b0, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            idx = a + 8'(i);
            rq.push_back('{last: (i == int'(l)), data: exp_mem[idx]});
            n_rd++;
        end
    endtask

    // Waits for all expected responses; junk wd_valid must be ignored meanwhile.
    task automatic wait_drain();
        int n = 0;
        while (rq.size() != 0 && n < 2000) begin
            wd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("wd_ready_outside_write", {31'd0, wd_ready}, 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        wd_valid = 1'b0;
        if (rq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d required=0 pending", rq.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    // ---------------- main sequence
    initial begin
        logic [7:0] ra;
        logic [1:0] rl;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_wd_ready",  {31'd0, wd_ready},  32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data",  rsp_data,           32'd0);
        chk("rst_rsp_last",  {31'd0, rsp_last},  32'd0);
        chk("rst_mem_addr",  {24'd0, mem_addr},  32'd0);
        chk("rst_mem_din",   mem_din,            32'd0);
        chk("rst_mem_rw",    {31'd0, mem_rw},    32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready_first", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("post_rst_cmd_ready_then", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Write A0..A3 at FC, then read back
        do_write(8'hFC, 2'd3, 1'b0, 32'hA0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            ra = 8'hFC + 8'(i);
            chk("ram_contents_fc", ram[ra], 32'hA0 + 32'(i));
        end
        do_read(8'hFC, 2'd3);
        wait_drain();

        // Wrap-around read FE,FF,00,01
        do_read(8'hFE, 2'd3);
        wait_drain();

        // Back-pressure: FIFO fills, then releases without loss or duplication
        rdy_mode = 1;
        do_read(8'h10, 2'd3);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("stall_rsp_head",  rsp_data, exp_mem[8'h10]);
        chk("stall_rsp_last",  {31'd0, rsp_last}, 32'd0);
        chk("stall_pending",   32'(rq.size()), 32'd4);
        rdy_mode = 2;
        wait_drain();
        rdy_mode = 0;

        // Write with data gaps
        do_write(8'h40, 2'd3, 1'b1, 32'd0, 1'b1);
        do_read(8'h40, 2'd3);
        wait_drain();

        // Reset in the middle of a read burst
        rdy_mode = 1;
        do_read(8'hF0, 2'd3);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_mem_rw",    {31'd0, mem_rw},    32'd1);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rq.delete();
        n_wr = 0;
        n_rd = 0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle_cmd_ready0", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("midrst_idle_cmd_ready1", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 3 writes + 2 reads after reset
        do_write(8'h80, 2'd2, 1'b1, 32'd0, 1'b0);
        do_read(8'h80, 2'd1);
        wait_drain();
`ifdef RAM_CTRL_STATS_EN
        chk("stat_wr_3", {16'd0, stat_wr}, 32'd3);
        chk("stat_rd_2", {16'd0, stat_rd}, 32'd2);
`endif

        // Randomised bursts
        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom);
            rl = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(ra, rl, 1'b1, 32'd0, 1'($urandom_range(0, 1)));
            end else begin
                do_read(ra, rl);
                if ($urandom_range(0, 1) == 1) wait_drain();
            end
        end
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        chk("final_rsp_queue_empty", 32'(rq.size()), 32'd0);
        chk("final_wr_queue_empty",  32'(wq.size()), 32'd0);
        chk("final_idle_cmd_ready",  {31'd0, cmd_ready}, 32'd1);
`ifdef RAM_CTRL_STATS_EN
        chk("final_stat_wr", {16'd0, stat_wr}, 32'(n_wr));
        chk("final_stat_rd", {16'd0, stat_rd}, 32'(n_rd));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
